lock_code_debouncer: RTL



---
 rtl/lock_pkg.sv | 19 +
 rtl/lock_code_debouncer_sync2.sv | 29 ++
 rtl/lock_code_debouncer.sv | 98 +++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared constants and types for the combination-lock input stage and sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lock_pkg;

  localparam int LOCK_CODE_W         = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

  // Combination entries, code_in[4:0] order, shared with the sequence detector.
  localparam logic [LOCK_CODE_W-1:0] LOCK_CODE_0 = 5'b10000;
  localparam logic [LOCK_CODE_W-1:0] LOCK_CODE_1 = 5'b01100;
  localparam logic [LOCK_CODE_W-1:0] LOCK_CODE_2 = 5'b11101;

endpackage

// File: rtl/lock_code_debouncer_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
// Latency: 2 clk edges from input to q_o.
// Backpressure: none; free-running, samples every cycle.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lock_code_debouncer.sv
// Synchronise, debounce and strobe each newly settled keypad code once (LOCK_CODE_RELEASE_EN: zero = release).
// Latency: clean step strobes after DEBOUNCE_CYCLES+3 clk edges; all outputs registered.
// Backpressure: none; the strobe is a single-cycle event with no handshake.
module lock_code_debouncer
  import lock_pkg::*;
#(
  parameter int WIDTH           = LOCK_CODE_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  output logic [WIDTH-1:0] code_out,
  output logic             code_stb,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q;
  deb_state_t       state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             stb_q, stb_d;
`ifdef LOCK_CODE_RELEASE_EN
  logic             rel_q, rel_d;
`endif

  sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (code_in),
    .q_o (sync_q)
  );

  // Debounce FSM state, candidate, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      stb_q   <= 1'b0;
`ifdef LOCK_CODE_RELEASE_EN
      rel_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      stb_q   <= stb_d;
`ifdef LOCK_CODE_RELEASE_EN
      rel_q   <= rel_d;
`endif
    end
  end

  // Any change restarts settling; a full quiet window commits the candidate.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    stb_d   = 1'b0;
`ifdef LOCK_CODE_RELEASE_EN
    rel_d   = rel_q;
`endif
    if (sync_q != cand_q) begin
      cand_d  = sync_q;
      cnt_d   = '0;
      state_d = SETTLING;
    end else if (state_q == SETTLING && cnt_q == CNT_LAST) begin
      state_d = STABLE;
      out_d   = cand_q;
`ifdef LOCK_CODE_RELEASE_EN
      // Zero re-arms the strobe silently; a non-zero code strobes only once per release.
      if (cand_q == '0) begin
        rel_d = 1'b1;
      end else if (rel_q && cand_q != out_q) begin
        stb_d = 1'b1;
        rel_d = 1'b0;
      end
`else
      stb_d   = (cand_q != out_q);
`endif
    end else if (state_q == SETTLING) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign code_out = out_q;
  assign code_stb = stb_q;
  assign busy     = (state_q == SETTLING);

endmodule
